// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds a + b + cin one full-adder stage per
// clock, LSB first, and presents {cout, s} with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_shifted;

  // Next-state and datapath: one full-adder stage per ADD cycle, results
  // copied to the output registers only on the final bit.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    s_d         = s_q;
    cout_d      = cout_q;

    sum_bit     = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    carry_nxt   = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
    sum_shifted = {sum_bit, sum_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        sum_d   = sum_shifted;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          s_d     = sum_shifted;
          cout_d  = carry_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scenario-driven bench for serial_adder_ctrl (WIDTH=8) with a result
// scoreboard checked by a monitor at every done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_res = '0;
  bit         mon_en = 1'b0;
  logic       rst_at_edge = 1'b1;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Remember whether the most recent edge was a reset edge.
  always @(posedge clk) rst_at_edge <= rst;

  // Monitor: scoreboard compare on done, busy/done exclusivity, result hold.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy && done) begin
        failures++;
        $display("[TB] FAIL busy_done_overlap busy=%b done=%b required not both 1", busy, done);
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_done got {cout,s}=%h with no pending operation", {cout, s});
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          if ({cout, s} !== e) begin
            failures++;
            $display("[TB] FAIL result got {cout,s}=%h required %h", {cout, s}, e);
          end
        end
        last_res = {cout, s};
      end else begin
        checks++;
        if ({cout, s} !== last_res && !(rst_at_edge && {cout, s} === '0)) begin
          failures++;
          $display("[TB] FAIL result_hold got {cout,s}=%h required %h", {cout, s}, last_res);
        end
        if (rst_at_edge) last_res = {cout, s};
      end
    end
  end

  // One operation: call #1 after a posedge with the DUT idle; returns #1
  // after the edge that takes the DUT back to IDLE.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic [W:0] expv, input bit ign);
    int got;
    a = ia; b = ib; cin = icin; start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int j = 1; j <= W + 4; j++) begin
      @(negedge clk);
      checks++;
      if (busy !== (j <= W)) begin
        failures++;
        $display("[TB] FAIL busy_cycle j=%0d got %b required %b", j, busy, (j <= W));
      end
      if (done === 1'b1) begin
        got = j;
        break;
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (ign && (j == 3)) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end
      if (ign && (j == 4)) start = 1'b0;
    end
    checks++;
    if (got != W + 1) begin
      failures++;
      $display("[TB] FAIL latency got done at cycle %0d required %0d", got, W + 1);
    end
    if (ign) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cout, s} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state got busy=%b done=%b cout=%b s=%h required all 0", busy, done, cout, s);
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_first();
    do_op(8'h00, 8'h00, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic test_directed();
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0);
    do_op(8'h3C, 8'h0F, 1'b1, 9'h04C, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_op(8'h10, 8'h20, 1'b0, 9'h030, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL no_queued_start got busy=%b done=%b required 0 0", busy, done);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, s} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_state got busy=%b done=%b cout=%b s=%h required all 0", busy, done, cout, s);
    end
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abort_no_done got done=%b required 0", done);
      end
    end
    @(posedge clk); #1;
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t[3];
    int n = 0;
    int idle_low = 0;
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(9'h047);
    for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
      @(negedge clk);
      if (n >= 1 && !busy && !done) idle_low++;
      if (done) begin
        t[n] = cyc;
        n++;
      end
    end
    start = 1'b0;
    checks++;
    if (n != 3) begin
      failures++;
      $display("[TB] FAIL b2b_count got %0d done pulses required 3", n);
    end else begin
      checks++;
      if (t[1] - t[0] != W + 2 || t[2] - t[1] != W + 2) begin
        failures++;
        $display("[TB] FAIL b2b_spacing got %0d,%0d required %0d", t[1] - t[0], t[2] - t[1], W + 2);
      end
      checks++;
      if (idle_low != 2) begin
        failures++;
        $display("[TB] FAIL b2b_idle got %0d idle cycles required 2", idle_low);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  // Scenario sequence, then final scoreboard drain check and summary.
  initial begin
    test_reset();
    test_zero_first();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to add a, b, cin; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high while an addition is in progress (state ADD).
REQ-009 done  output  1  registered one-cycle pulse; result valid.
REQ-010 s  output  WIDTH  registered sum result.
REQ-011 cout  output  1  registered carry-out result.

Function
REQ-012 Block SHALL compute {cout,s} = a + b + cin by sequencing one 1-bit full-adder stage, LSB first, one bit per clock.
REQ-013 FSM states SHALL be IDLE, ADD, DONE; encoding is free.
REQ-014 IDLE: start=1 at a rising edge SHALL load internal shift registers with a and b, set internal carry to cin, clear bit counter to 0, and move to ADD.
REQ-015 IDLE: start=0 SHALL leave state and all outputs unchanged.
REQ-016 ADD: each cycle SHALL form sum bit = opA[0]^opB[0]^carry and next carry = majority(opA[0],opB[0],carry), shift opA/opB right by one, shift sum bit into internal sum register from MSB, and increment counter.
REQ-017 ADD SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, the FSM SHALL move to DONE and copy internal sum to s and final carry to cout.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, for exactly one cycle.
REQ-019 DONE SHALL return to IDLE unconditionally on the next edge; done SHALL deassert there.
REQ-020 s and cout SHALL change only on the transition into DONE or on reset; between results they hold the last result.
REQ-021 busy SHALL be 1 exactly in ADD; busy and done SHALL never be high together.
REQ-022 start asserted in ADD or DONE SHALL be ignored (no queuing); a, b, cin changes during ADD SHALL not affect the result.
REQ-023 start held high continuously SHALL launch a new addition on the first IDLE edge after each DONE (one idle cycle between operations, throughput one result per WIDTH+2 cycles).
REQ-024 Overflow: cout SHALL carry bit WIDTH of the true sum; no other wrap or saturation.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, s=0, cout=0, counter and internal registers to 0, overriding start.
REQ-026 Reset asserted mid-operation (in ADD or DONE) SHALL abort the addition with no done pulse and no update of s/cout except clearing to 0.
REQ-027 First start SHALL be accepted on the first edge where rst=0 and state is IDLE.

Verification (WIDTH=8)
REQ-028 a=0x00,b=0x00,cin=0, start at edge k -> done high after edge k+8, s=0x00, cout=0, busy high for 8 cycles.
REQ-029 a=0xFF,b=0x01,cin=0 -> s=0x00, cout=1; a=0xA5,b=0x5A,cin=1 -> s=0x00, cout=1; a=0x3C,b=0x0F,cin=1 -> s=0x4C, cout=0.
REQ-030 Start 0x10+0x20, then pulse start with a=0xFF,b=0xFF during ADD -> ignored; result s=0x30, cout=0; a, b toggled during ADD do not alter it.
REQ-031 Reset asserted 4 cycles into ADD of 0xFF+0x01 -> next cycle busy=0, done=0, s=0x00, cout=0; no done pulse follows; a subsequent start completes normally.
REQ-032 start held high for three operations -> done pulses spaced exactly 10 cycles apart, busy low for one cycle between each.
REQ-033 1000 random (a,b,cin) with random start gaps -> every {cout,s} equals a+b+cin, compared against a reference model at each done.
